// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one MOC-handshake RAM port between fetch and data requesters
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_enable,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          moc,
    output logic          busy,
    output logic          bus_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          last_fetch_q;
    logic          owner_fetch_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_done_q;
    logic          d_done_q;
    logic          mem_enable_q;
    logic          mem_rw_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          busy_q;
    logic          bus_err_q;

    logic          grant_any_d;
    logic          grant_fetch_d;
    logic          finish_d;
    logic [DW-1:0] capture_d;

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        grant_any_d   = if_req | d_req;
        grant_fetch_d = if_req & (~d_req | ~last_fetch_q);
        finish_d      = moc | (cnt_q == CW'(TIMEOUT - 1));
        capture_d     = moc ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_fetch_q  <= 1'b0;
            owner_fetch_q <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any_d) begin
                        owner_fetch_q <= grant_fetch_d;
                        last_fetch_q  <= grant_fetch_d;
                        mem_rw_q      <= grant_fetch_d ? 1'b1 : d_rw;
                        mem_addr_q    <= grant_fetch_d ? if_addr : d_addr;
                        mem_wdata_q   <= grant_fetch_d ? '0 : d_wdata;
                        mem_enable_q  <= 1'b1;
                        busy_q        <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish_d) begin
                        // A timed-out read returns zero rather than whatever is on the bus.
                        if (!moc) begin
                            bus_err_q <= 1'b1;
                        end
                        if (owner_fetch_q) begin
                            if_done_q <= 1'b1;
                            if (mem_rw_q) begin
                                if_rdata_q <= capture_d;
                            end
                        end else begin
                            d_done_q <= 1'b1;
                            if (mem_rw_q) begin
                                d_rdata_q <= capture_d;
                            end
                        end
                        mem_enable_q <= 1'b0;
                        state_q      <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!moc) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    mem_enable_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_done    = if_done_q;
    assign d_rdata    = d_rdata_q;
    assign d_done     = d_done_q;
    assign mem_enable = mem_enable_q;
    assign mem_rw     = mem_rw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        moc;
    logic        busy;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;
    int if_done_cnt = 0;
    int d_done_cnt  = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .moc(moc),
        .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Done pulses are tallied at the edge after they appear, so each is seen exactly once.
    always @(posedge clk) begin
        if (if_done === 1'b1) if_done_cnt <= if_done_cnt + 1;
        if (d_done === 1'b1) d_done_cnt <= d_done_cnt + 1;
    end

    // Responder: waits for mem_enable, holds off moc for dly cycles, then returns rd.
    task automatic serve(input int dly, input logic [31:0] rd,
                         output logic [31:0] a, output logic rw, output logic [31:0] wd,
                         output bit stable, output bit ok);
        int n;
        ok = 1'b0;
        stable = 1'b1;
        a = '0; rw = 1'b0; wd = '0;
        n = 0;
        while (mem_enable !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (mem_enable !== 1'b1) return;
        a = mem_addr; rw = mem_rw; wd = mem_wdata;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (mem_enable !== 1'b1 || mem_addr !== a || mem_rw !== rw || mem_wdata !== wd)
                stable = 1'b0;
        end
        mem_rdata = rd;
        moc = 1'b1;
        @(negedge clk);
        ok = 1'b1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({mem_enable, mem_rw, busy, bus_err, if_done, d_done} !== 6'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b rw=%b busy=%b err=%b addr=%h ird=%h drd=%h, all required 0",
                     mem_enable, mem_rw, busy, bus_err, mem_addr, if_rdata, d_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch;
        logic [31:0] a, wd;
        logic rw;
        bit stable, ok;
        int c0;
        c0 = if_done_cnt;
        if_addr = 32'h40;
        if_req = 1'b1;
        serve(2, 32'h8C010004, a, rw, wd, stable, ok);
        n_tests++;
        if (!ok || a !== 32'h40 || rw !== 1'b1 || wd !== 32'h0 || !stable) begin
            n_fail++;
            $display("FAIL fetch_bus: ok=%0d addr=%h rw=%b wdata=%h stable=%0d, required addr=00000040 rw=1 wdata=0 stable",
                     ok, a, rw, wd, stable);
        end
        n_tests++;
        if (if_done !== 1'b1 || mem_enable !== 1'b0 || if_rdata !== 32'h8C010004 || d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_done: if_done=%b en=%b if_rdata=%h d_done=%b, required 1 0 8c010004 0",
                     if_done, mem_enable, if_rdata, d_done);
        end
        if_req = 1'b0;
        moc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (if_done !== 1'b0 || busy !== 1'b0 || if_done_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL fetch_pulse: if_done=%b busy=%b pulses=%0d, required 0 0 1",
                     if_done, busy, if_done_cnt - c0);
        end
    endtask

    task automatic test_data;
        logic [31:0] a, wd;
        logic rw;
        bit stable, ok;
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h200; d_wdata = 32'h0;
        serve(0, 32'h12345678, a, rw, wd, stable, ok);
        n_tests++;
        if (!ok || a !== 32'h200 || rw !== 1'b1 || d_done !== 1'b1 || d_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL data_read: ok=%0d addr=%h rw=%b d_done=%b d_rdata=%h, required 00000200 1 1 12345678",
                     ok, a, rw, d_done, d_rdata);
        end
        d_req = 1'b0; moc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        serve(3, 32'hFFFF0000, a, rw, wd, stable, ok);
        n_tests++;
        if (!ok || a !== 32'h100 || rw !== 1'b0 || wd !== 32'hDEADBEEF || !stable) begin
            n_fail++;
            $display("FAIL data_write_bus: ok=%0d addr=%h rw=%b wdata=%h stable=%0d, required 00000100 0 deadbeef stable",
                     ok, a, rw, wd, stable);
        end
        n_tests++;
        if (d_done !== 1'b1 || d_rdata !== 32'h12345678 || if_rdata !== 32'h8C010004) begin
            n_fail++;
            $display("FAIL data_write_rdata: d_done=%b d_rdata=%h if_rdata=%h, required 1 12345678 8c010004",
                     d_done, d_rdata, if_rdata);
        end
        d_req = 1'b0; moc = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [31:0] a, wd;
        logic rw;
        bit stable, ok;
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'h44; exp_addr[1] = 32'h300; exp_addr[2] = 32'h44;
        do_reset();
        if_addr = 32'h44; d_addr = 32'h300; d_rw = 1'b1;
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(1, 32'hA0 + 32'(i), a, rw, wd, stable, ok);
            n_tests++;
            if (!ok || a !== exp_addr[i] || if_done !== (i != 1) || d_done !== (i == 1)) begin
                n_fail++;
                $display("FAIL round_robin_%0d: ok=%0d addr=%h if_done=%b d_done=%b, required addr=%h",
                         i, ok, a, if_done, d_done, exp_addr[i]);
            end
            moc = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (if_rdata !== 32'hA2 || d_rdata !== 32'hA1) begin
            n_fail++;
            $display("FAIL round_robin_rdata: if_rdata=%h d_rdata=%h, required 000000a2 000000a1", if_rdata, d_rdata);
        end
    endtask

    task automatic test_timeout;
        logic [31:0] a, wd;
        logic rw;
        bit stable, ok;
        int n, cyc;
        d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h400;
        n = 0;
        while (mem_enable !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        cyc = 0;
        while (mem_enable === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc !== 64 || d_done !== 1'b1 || bus_err !== 1'b1 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout: access_cycles=%0d d_done=%b bus_err=%b d_rdata=%h, required 64 1 1 0",
                     cyc, d_done, bus_err, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        if_addr = 32'h48; if_req = 1'b1;
        serve(1, 32'h11112222, a, rw, wd, stable, ok);
        n_tests++;
        if (!ok || if_done !== 1'b1 || if_rdata !== 32'h11112222 || bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL bus_err_sticky: ok=%0d if_done=%b if_rdata=%h bus_err=%b, required 1 11112222 1",
                     ok, if_done, if_rdata, bus_err);
        end
        if_req = 1'b0; moc = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_moc_hold;
        logic [31:0] a, wd;
        logic rw;
        bit stable, ok;
        bit bad;
        int c0;
        c0 = if_done_cnt;
        if_addr = 32'h4C; if_req = 1'b1;
        serve(0, 32'h3333, a, rw, wd, stable, ok);
        bad = !ok;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_enable !== 1'b0 || busy !== 1'b1 || if_done !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL release_wait: en=%b busy=%b if_done=%b while moc held, required 0 1 0",
                     mem_enable, busy, if_done);
        end
        moc = 1'b0; if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || mem_enable !== 1'b0 || if_done_cnt - c0 !== 1) begin
            n_fail++;
            $display("FAIL release_exit: busy=%b en=%b pulses=%0d, required 0 0 1",
                     busy, mem_enable, if_done_cnt - c0);
        end
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] a, wd;
        logic rw;
        bit stable, ok;
        int n, c0;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h500; d_wdata = 32'h5;
        n = 0;
        while (mem_enable !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        c0 = d_done_cnt;
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (n >= 10 || mem_enable !== 1'b0 || busy !== 1'b0 || bus_err !== 1'b0 || d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_access: en=%b busy=%b bus_err=%b d_done=%b, required 0 0 0 0",
                     mem_enable, busy, bus_err, d_done);
        end
        d_req = 1'b0; reset = 1'b0;
        moc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || mem_enable !== 1'b0 || d_done_cnt !== c0) begin
            n_fail++;
            $display("FAIL idle_moc_ignored: busy=%b en=%b extra_done=%0d, required 0 0 0",
                     busy, mem_enable, d_done_cnt - c0);
        end
        moc = 1'b0;
        @(negedge clk);
        if_addr = 32'h80; if_req = 1'b1;
        serve(1, 32'h55AA, a, rw, wd, stable, ok);
        n_tests++;
        if (!ok || a !== 32'h80 || if_done !== 1'b1 || if_rdata !== 32'h55AA) begin
            n_fail++;
            $display("FAIL after_reset_access: ok=%0d addr=%h if_done=%b if_rdata=%h, required 00000080 1 000055aa",
                     ok, a, if_done, if_rdata);
        end
        if_req = 1'b0; moc = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; moc = 1'b0;
        test_reset();
        test_fetch();
        test_data();
        test_round_robin();
        test_timeout();
        test_moc_hold();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
